// File: rtl/issue_pkg.sv
// Micro-op layout, opcode and ALU encodings shared by the issue
// scheduler and anything that builds or inspects micro-ops.
package issue_pkg;

  localparam int UOP_W = 65;

  localparam int OPC_LSB   = 0;
  localparam int RD_LSB    = 7;
  localparam int RS1_LSB   = 12;
  localparam int RS2_LSB   = 17;
  localparam int IMM_LSB   = 22;
  localparam int F3_LSB    = 54;
  localparam int LS_BIT    = 57;
  localparam int ASRC_BIT  = 58;
  localparam int RW_BIT    = 59;
  localparam int ALUC_LSB  = 60;
  localparam int BMS_BIT   = 64;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  // Field order mirrors the bit offsets above, MSB first.
  typedef struct packed {
    logic        bms;
    logic [3:0]  aluctl;
    logic        regwrite;
    logic        alusrc;
    logic        loadstore;
    logic [2:0]  func3;
    logic [31:0] imm;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } uop_t;

  function automatic logic [31:0] reg_bit(
    input logic [4:0] r
  );
    reg_bit = '0;
    if (r != 5'd0) reg_bit[r] = 1'b1;
  endfunction

endpackage

// File: rtl/issue_scheduler_fifo.sv
// Circular micro-op queue: registered storage, no bypass from push
// to head, synchronous clear.
module issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_clear,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset && !i_clear)
      r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue with RAW/WAW scoreboard and LSU gating.
// ISSUE_SCHEDULER_WB_BYPASS_EN lets a same-cycle writeback unblock.
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               dec_valid,
  output logic               dec_ready,
  input  logic [UOP_W-1:0]   dec_uop,
  output logic               iss_valid,
  input  logic               iss_ready,
  output logic [UOP_W-1:0]   iss_uop,
  input  logic               lsu_busy,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic               flush,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]      w_count;
  logic [UOP_W-1:0]   w_head;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [4:0]         w_rd;
  logic [4:0]         w_rs1;
  logic [4:0]         w_rs2;
  logic               w_rw;
  logic               w_ls;
  logic [31:0]        w_wb_clr;
  logic [31:0]        w_iss_set;
  logic [31:0]        w_pend_eff;
  logic               w_haz;
  logic               w_mem_blk;
  logic               w_stall;
  logic [31:0]        r_pend;
  logic [STALL_W-1:0] r_stall;

  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == CW'(DEPTH));

  assign dec_ready = !reset && !flush && !w_full;
  assign w_push    = dec_valid && dec_ready;
  assign w_pop     = iss_valid && iss_ready;

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UOP_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_data  (dec_uop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_rd  = w_head[RD_LSB +: 5];
  assign w_rs1 = w_head[RS1_LSB +: 5];
  assign w_rs2 = w_head[RS2_LSB +: 5];
  assign w_rw  = w_head[RW_BIT];
  assign w_ls  = w_head[LS_BIT];

  assign w_wb_clr = wb_valid ? reg_bit(wb_rd) : '0;

`ifdef ISSUE_SCHEDULER_WB_BYPASS_EN
  assign w_pend_eff = r_pend & ~w_wb_clr;
`else
  assign w_pend_eff = r_pend;
`endif

  assign w_haz =
    ((w_rs1 != 5'd0) && w_pend_eff[w_rs1]) ||
    ((w_rs2 != 5'd0) && w_pend_eff[w_rs2]) ||
    (w_rw && (w_rd != 5'd0) && w_pend_eff[w_rd]);

  assign w_mem_blk = w_ls && lsu_busy;

  assign iss_valid = !w_empty && !flush && !reset &&
                     !w_haz && !w_mem_blk;
  assign iss_uop   = w_empty ? '0 : w_head;

  assign w_iss_set = (w_pop && w_rw) ? reg_bit(w_rd) : '0;

  // Set is applied after clear: the issuing op is the younger writer.
  always_ff @(posedge clk) begin
    if (reset)
      r_pend <= '0;
    else
      r_pend <= ((r_pend & ~w_wb_clr) | w_iss_set) & ~32'h1;
  end

  assign w_stall = !w_empty && !iss_valid && !flush;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall <= '0;
    else if (w_stall && (r_stall != {STALL_W{1'b1}}))
      r_stall <= r_stall + 1'b1;
  end

  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed scenarios plus randomized
// traffic against a queue/scoreboard reference model.
`timescale 1ns/1ps
module tb_issue_scheduler;
  import issue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int STALL_W = 16;
`ifdef ISSUE_SCHEDULER_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, dec_valid, iss_ready;
  logic lsu_busy, wb_valid, flush;
  logic [4:0] wb_rd;
  uop_t dec_uop;
  logic dec_ready, iss_valid;
  logic [UOP_W-1:0] iss_uop;
  logic [STALL_W-1:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  uop_t        mq[$];
  logic [31:0] mpend;
  int          mstall;

  always #5 clk = ~clk;

  issue_scheduler #(
    .DEPTH   (DEPTH),
    .STALL_W (STALL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_uop   (dec_uop),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_uop   (iss_uop),
    .lsu_busy  (lsu_busy),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  function automatic uop_t mk(
    input logic [6:0] opc,
    input logic [4:0] rd, rs1, rs2,
    input logic rw, ls,
    input logic [3:0] alu
  );
    uop_t u;
    u = '0;
    u.opcode    = opc;
    u.rd        = rd;
    u.rs1       = rs1;
    u.rs2       = rs2;
    u.regwrite  = rw;
    u.loadstore = ls;
    u.aluctl    = alu;
    u.alusrc    = (opc != OP_R);
    u.imm       = $urandom;
    u.func3     = 3'($urandom_range(0, 7));
    u.bms       = 1'($urandom_range(0, 1));
    return u;
  endfunction

  function automatic uop_t rnd_uop();
    logic [4:0] rd, r1, r2;
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    unique case ($urandom_range(0, 3))
      0: return mk(OP_R, rd, r1, r2, 1, 0, ALU_XOR);
      1: return mk(OP_I, rd, r1, 0, 1, 0, ALU_ADD);
      2: return mk(OP_LOAD, rd, r1, 0, 1, 1, ALU_ADD);
      default: return mk(OP_STORE, 0, r1, r2, 0, 1, ALU_ADD);
    endcase
  endfunction

  // Register is still owed a write (bypass hides a same-cycle wb).
  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd0 || !mpend[r]) return 1'b0;
    if (BYP && wb_valid && wb_rd == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_iv();
    uop_t h;
    if (reset || flush || mq.size() == 0) return 1'b0;
    h = mq[0];
    if (m_busy(h.rs1) || m_busy(h.rs2)) return 1'b0;
    if (h.regwrite && m_busy(h.rd)) return 1'b0;
    if (h.loadstore && lsu_busy) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_dr();
    return !reset && !flush && mq.size() < DEPTH;
  endfunction

  function automatic uop_t m_head();
    if (mq.size() == 0) return '0;
    return mq[0];
  endfunction

  task automatic tick();
    bit iv, dr;
    uop_t h;
    @(posedge clk);
    iv = m_iv();
    dr = m_dr();
    h  = m_head();
    if (reset) begin
      mq.delete();
      mpend  = '0;
      mstall = 0;
    end else begin
      if (mq.size() != 0 && !iv && !flush &&
          mstall < (2 ** STALL_W) - 1)
        mstall++;
      if (wb_valid && wb_rd != 0) mpend[wb_rd] = 1'b0;
      if (iv && iss_ready && h.regwrite && h.rd != 0)
        mpend[h.rd] = 1'b1;
      if (flush) begin
        mq.delete();
      end else begin
        if (iv && iss_ready) void'(mq.pop_front());
        if (dr && dec_valid) mq.push_back(dec_uop);
      end
    end
    #1;
  endtask

  task automatic idle();
    dec_valid = 0;
    iss_ready = 0;
    lsu_busy  = 0;
    wb_valid  = 0;
    wb_rd     = 0;
    flush     = 0;
    dec_uop   = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle();
    reset     = 1;
    dec_valid = 1;
    iss_ready = 1;
    dec_uop   = mk(OP_R, 5, 1, 2, 1, 0, ALU_ADD);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if (dec_ready !== 1'b0) begin
        nerr++;
        $display("FAIL rst_ready c%0d got %b want 0", i, dec_ready);
      end
      nvec++;
      if (iss_valid !== 1'b0) begin
        nerr++;
        $display("FAIL rst_valid c%0d got %b want 0", i, iss_valid);
      end
      tick();
    end
    @(negedge clk);
    nvec++;
    if (stall_cnt !== '0) begin
      nerr++;
      $display("FAIL rst_stall got %0d want 0", stall_cnt);
    end
    tick();
    reset     = 0;
    dec_valid = 0;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b0 || iss_uop !== '0) begin
      nerr++;
      $display("FAIL rst_empty got v=%b u=%h want 0/0",
               iss_valid, iss_uop);
    end
    nvec++;
    if (dec_ready !== 1'b1) begin
      nerr++;
      $display("FAIL rst_release got %b want 1", dec_ready);
    end
    tick();
  endtask

  task automatic test_raw_stall();
    uop_t u1, u2;
    bit exp;
    do_reset();
    u1 = mk(OP_R, 5, 1, 2, 1, 0, ALU_ADD);
    u2 = mk(OP_I, 6, 5, 0, 1, 0, ALU_ADD);
    iss_ready = 1;
    dec_valid = 1;
    dec_uop   = u1;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b0) begin
      nerr++;
      $display("FAIL raw_nobypass got %b want 0", iss_valid);
    end
    tick();
    dec_uop = u2;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b1 || iss_uop !== u1) begin
      nerr++;
      $display("FAIL raw_first got v=%b u=%h want 1/%h",
               iss_valid, iss_uop, u1);
    end
    tick();
    dec_valid = 0;
    for (int k = 0; k < 4; k++) begin
      wb_valid = (k == 2);
      wb_rd    = 5;
      exp = BYP ? (k == 2) : (k == 3);
      @(negedge clk);
      nvec++;
      if (iss_valid !== exp) begin
        nerr++;
        $display("FAIL raw_dep k=%0d got %b want %b",
                 k, iss_valid, exp);
      end
      if (exp) begin
        nvec++;
        if (iss_uop !== u2) begin
          nerr++;
          $display("FAIL raw_uop got %h want %h", iss_uop, u2);
        end
      end
      tick();
    end
    wb_valid = 0;
    @(negedge clk);
    nvec++;
    if (stall_cnt !== (BYP ? 16'd2 : 16'd3)) begin
      nerr++;
      $display("FAIL raw_stall got %0d want %0d",
               stall_cnt, BYP ? 2 : 3);
    end
    tick();
  endtask

  task automatic test_full();
    uop_t f[5];
    do_reset();
    for (int i = 0; i < 5; i++)
      f[i] = mk(OP_I, 5'(10 + i), 1, 0, 0, 0, ALU_OR);
    dec_valid = 1;
    for (int i = 0; i < 4; i++) begin
      dec_uop = f[i];
      @(negedge clk);
      nvec++;
      if (dec_ready !== 1'b1) begin
        nerr++;
        $display("FAIL full_fill i=%0d got %b want 1", i, dec_ready);
      end
      tick();
    end
    dec_uop = f[4];
    @(negedge clk);
    nvec++;
    if (dec_ready !== 1'b0) begin
      nerr++;
      $display("FAIL full_ready got %b want 0", dec_ready);
    end
    nvec++;
    if (iss_valid !== 1'b1 || iss_uop !== f[0]) begin
      nerr++;
      $display("FAIL full_head got v=%b u=%h want 1/%h",
               iss_valid, iss_uop, f[0]);
    end
    tick();
    iss_ready = 1;
    @(negedge clk);
    nvec++;
    if (dec_ready !== 1'b0) begin
      nerr++;
      $display("FAIL full_nopt got %b want 0", dec_ready);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (dec_ready !== 1'b1) begin
      nerr++;
      $display("FAIL full_after_pop got %b want 1", dec_ready);
    end
    dec_valid = 0;
    for (int i = 1; i < 4; i++) begin
      if (i > 1) @(negedge clk);
      nvec++;
      if (iss_valid !== 1'b1 || iss_uop !== f[i]) begin
        nerr++;
        $display("FAIL full_order i=%0d got v=%b u=%h want 1/%h",
                 i, iss_valid, iss_uop, f[i]);
      end
      tick();
    end
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b0 || iss_uop !== '0) begin
      nerr++;
      $display("FAIL full_dropped got v=%b u=%h want 0/0",
               iss_valid, iss_uop);
    end
    tick();
  endtask

  task automatic test_lsu_block();
    uop_t lw;
    do_reset();
    lw = mk(OP_LOAD, 10, 1, 0, 1, 1, ALU_ADD);
    dec_valid = 1;
    dec_uop   = lw;
    iss_ready = 1;
    tick();
    dec_valid = 0;
    lsu_busy  = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (iss_valid !== 1'b0) begin
        nerr++;
        $display("FAIL lsu_block c%0d got %b want 0", i, iss_valid);
      end
      tick();
    end
    lsu_busy = 0;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b1 || iss_uop !== lw) begin
      nerr++;
      $display("FAIL lsu_go got v=%b u=%h want 1/%h",
               iss_valid, iss_uop, lw);
    end
    tick();
    @(negedge clk);
    nvec++;
    if (stall_cnt !== 16'd3) begin
      nerr++;
      $display("FAIL lsu_stall got %0d want 3", stall_cnt);
    end
    tick();
  endtask

  task automatic test_flush();
    uop_t a, b, c, d, e, g;
    do_reset();
    a = mk(OP_I, 7, 1, 0, 1, 0, ALU_ADD);
    b = mk(OP_R, 11, 2, 3, 1, 0, ALU_XOR);
    c = mk(OP_R, 12, 2, 3, 1, 0, ALU_XOR);
    d = mk(OP_R, 13, 2, 3, 1, 0, ALU_XOR);
    e = mk(OP_R, 14, 2, 3, 1, 0, ALU_XOR);
    g = mk(OP_I, 15, 7, 0, 1, 0, ALU_ADD);
    dec_valid = 1;
    dec_uop   = a;
    tick();
    dec_uop   = b;
    iss_ready = 1;
    tick();
    iss_ready = 0;
    dec_uop   = c;
    tick();
    dec_uop = d;
    tick();
    flush   = 1;
    dec_uop = e;
    @(negedge clk);
    nvec++;
    if (dec_ready !== 1'b0 || iss_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_comb got r=%b v=%b want 0/0",
               dec_ready, iss_valid);
    end
    tick();
    flush     = 0;
    dec_uop   = g;
    iss_ready = 1;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b0 || iss_uop !== '0) begin
      nerr++;
      $display("FAIL flush_empty got v=%b u=%h want 0/0",
               iss_valid, iss_uop);
    end
    nvec++;
    if (stall_cnt !== '0) begin
      nerr++;
      $display("FAIL flush_stall got %0d want 0", stall_cnt);
    end
    tick();
    dec_valid = 0;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b0 || iss_uop !== g) begin
      nerr++;
      $display("FAIL flush_pend7 got v=%b u=%h want 0/%h",
               iss_valid, iss_uop, g);
    end
    tick();
  endtask

  task automatic test_x0_set_wins();
    uop_t xa, xb, p, q, r;
    do_reset();
    xa = mk(OP_I, 0, 1, 0, 1, 0, ALU_ADD);
    xb = mk(OP_R, 0, 0, 0, 1, 0, ALU_OR);
    iss_ready = 1;
    dec_valid = 1;
    dec_uop   = xa;
    tick();
    dec_uop = xb;
    tick();
    dec_valid = 0;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b1 || iss_uop !== xb) begin
      nerr++;
      $display("FAIL x0_nostall got v=%b u=%h want 1/%h",
               iss_valid, iss_uop, xb);
    end
    tick();
    p = mk(OP_I, 9, 1, 0, 1, 0, ALU_ADD);
    q = mk(OP_R, 9, 9, 0, 1, 0, ALU_SRA);
    r = mk(OP_I, 12, 9, 0, 1, 0, ALU_ADD);
    dec_valid = 1;
    dec_uop   = p;
    tick();
    dec_uop = q;
    tick();
    dec_uop = r;
    @(negedge clk);
    nvec++;
    if (iss_valid !== 1'b0) begin
      nerr++;
      $display("FAIL sw_raw got %b want 0", iss_valid);
    end
    tick();
    dec_valid = 0;
    wb_valid  = 1;
    wb_rd     = 9;
    @(negedge clk);
    nvec++;
    if (iss_valid !== BYP) begin
      nerr++;
      $display("FAIL sw_wbcycle got %b want %b", iss_valid, BYP);
    end
    tick();
    wb_valid = 0;
    @(negedge clk);
    nvec++;
    if (iss_valid !== !BYP) begin
      nerr++;
      $display("FAIL sw_next got %b want %b", iss_valid, !BYP);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nvec++;
      if (iss_valid !== 1'b0 || iss_uop !== r) begin
        nerr++;
        $display("FAIL sw_kept c%0d got v=%b u=%h want 0/%h",
                 i, iss_valid, iss_uop, r);
      end
      tick();
    end
  endtask

  task automatic test_random();
    uop_t eh;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      dec_valid = 1'($urandom_range(0, 1));
      dec_uop   = rnd_uop();
      iss_ready = ($urandom_range(0, 3) != 0);
      lsu_busy  = ($urandom_range(0, 3) == 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      @(negedge clk);
      eh = m_head();
      nvec++;
      if (iss_valid !== m_iv()) begin
        nerr++;
        $display("FAIL rnd_valid n=%0d got %b want %b",
                 n, iss_valid, m_iv());
      end
      nvec++;
      if (dec_ready !== m_dr()) begin
        nerr++;
        $display("FAIL rnd_ready n=%0d got %b want %b",
                 n, dec_ready, m_dr());
      end
      nvec++;
      if (iss_uop !== eh) begin
        nerr++;
        $display("FAIL rnd_uop n=%0d got %h want %h", n, iss_uop, eh);
      end
      nvec++;
      if (stall_cnt !== STALL_W'(mstall)) begin
        nerr++;
        $display("FAIL rnd_stall n=%0d got %0d want %0d",
                 n, stall_cnt, mstall);
      end
      tick();
    end
    reset = 0;
  endtask

  initial begin
    mpend  = '0;
    mstall = 0;
    reset  = 1;
    idle();
    test_reset();
    test_raw_stall();
    test_full();
    test_lsu_block();
    test_flush();
    test_x0_set_wins();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
